// File: rtl/module_7seg_pkg.sv
// -----------------------------------------------------------------------------
// module_7seg_pkg
// Shared types and constants for the multiplexed 7-segment scanner.
//   seg_t        : abc_defg segment pattern, bit 6 = a ... bit 0 = g, active-high
//   SEG_BLANK    : all segments off
//   SEG_TABLE    : patterns for codes 0..F (letters A b C d E F for 10..15)
//   scan_state_t : scanner state (RESET, SCAN)
// -----------------------------------------------------------------------------
package module_7seg_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic {
        ST_RESET,
        ST_SCAN
    } scan_state_t;

    localparam seg_t SEG_BLANK = 7'b000_0000;

    localparam seg_t SEG_TABLE [16] = '{
        7'b111_1110,  // 0
        7'b011_0000,  // 1
        7'b110_1101,  // 2
        7'b111_1001,  // 3
        7'b011_0011,  // 4
        7'b101_1011,  // 5
        7'b101_1111,  // 6
        7'b111_0000,  // 7
        7'b111_1111,  // 8
        7'b111_0011,  // 9
        7'b111_0111,  // A
        7'b001_1111,  // b
        7'b100_1110,  // C
        7'b011_1101,  // d
        7'b100_1111,  // E
        7'b100_0111   // F
    };

endpackage

// File: rtl/module_7seg_scan_if.sv
// -----------------------------------------------------------------------------
// module_7seg_scan_if
// Bundle between the datapath and the display scanner.
//   data_i      : packed 4-bit digit codes, digit 0 in bits [3:0]
//   dp_i        : decimal-point request per digit
//   load_i      : capture data_i / dp_i into the scanner's shadow register
//   segmentos_o : abc_defg pattern of the active digit
//   dp_o        : decimal point of the active digit
//   anodos_o    : one-hot digit enable
// Modports: master = datapath side, slave = scanner.
// -----------------------------------------------------------------------------
interface module_7seg_scan_if #(
    parameter int N_DIGITS = 4
);
    import module_7seg_pkg::*;

    logic [4*N_DIGITS-1:0] data_i;
    logic [N_DIGITS-1:0]   dp_i;
    logic                  load_i;
    seg_t                  segmentos_o;
    logic                  dp_o;
    logic [N_DIGITS-1:0]   anodos_o;

    modport master (
        output data_i, dp_i, load_i,
        input  segmentos_o, dp_o, anodos_o
    );

    modport slave (
        input  data_i, dp_i, load_i,
        output segmentos_o, dp_o, anodos_o
    );

endinterface

// File: rtl/module_7seg_dec.sv
// -----------------------------------------------------------------------------
// module_7seg_dec
// Pure combinational 4-bit code to abc_defg decoder.
//   code_i : digit code 0..15
//   seg_o  : segment pattern; codes >= 10 blank when HEX_MODE = 0
// -----------------------------------------------------------------------------
module module_7seg_dec
    import module_7seg_pkg::*;
#(
    parameter int HEX_MODE = 1
) (
    input  logic [3:0] code_i,
    output seg_t       seg_o
);

    always_comb begin
        // NOTE: assign a default before any conditional override so no latch is inferred.
        seg_o = SEG_TABLE[code_i];
        if (HEX_MODE == 0 && code_i >= 4'd10) begin
            seg_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/module_7seg_scan.sv
// -----------------------------------------------------------------------------
// module_7seg_scan
// Time-multiplexed driver for N_DIGITS 7-segment digits. Latches the digit codes
// into a shadow register on load_i and scans one digit per REFRESH_DIV cycles.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : module_7seg_scan_if.slave (data_i, dp_i, load_i in;
//         segmentos_o, dp_o, anodos_o out, all registered)
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank leading zero digits
// (never digit 0); blanked digits keep their enable slot.
// -----------------------------------------------------------------------------
module module_7seg_scan
    import module_7seg_pkg::*;
#(
    parameter int N_DIGITS         = 4,
    parameter int REFRESH_DIV      = 27000,
    parameter int HEX_MODE         = 1,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    module_7seg_scan_if.slave    bus
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic                AN_LOW   = (ANODE_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{AN_LOW}};

    scan_state_t                state;
    logic [PRE_W-1:0]           pre;
    logic [IDX_W-1:0]           idx;
    logic [N_DIGITS-1:0][3:0]   sh_data;
    logic [N_DIGITS-1:0]        sh_dp;
    logic [N_DIGITS-1:0]        blank;
    logic [N_DIGITS-1:0]        an_sel;
    seg_t                       dec_seg;
    logic                       tick;

    seg_t                       seg_q;
    logic                       dp_q;
    logic [N_DIGITS-1:0]        an_q;

    assign tick = (pre == PRE_LAST);

    // Single decoder shared by all digits, fed with the currently selected nibble.
    module_7seg_dec #(
        .HEX_MODE (HEX_MODE)
    ) u_dec (
        .code_i (sh_data[idx]),
        .seg_o  (dec_seg)
    );

    always_comb begin
        an_sel      = '0;
        an_sel[idx] = 1'b1;
    end

    // Walk down from the most significant digit; a digit is blank while every
    // digit from the top down to it (inclusive) is zero. Digit 0 is never blank.
    always_comb begin
        blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = N_DIGITS - 1; i > 0; i--) begin
                lead     = lead && (sh_data[i] == 4'd0);
                blank[i] = lead;
            end
        end
`endif
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_RESET;
            pre     <= '0;
            idx     <= '0;
            sh_data <= '0;
            sh_dp   <= '0;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b0;
            an_q    <= AN_OFF;
        end else begin
            if (bus.load_i) begin
                sh_data <= bus.data_i;
                sh_dp   <= bus.dp_i;
            end

            case (state)
                // Outputs stay off for one cycle after reset release.
                ST_RESET: begin
                    state <= ST_SCAN;
                end

                ST_SCAN: begin
                    if (tick) begin
                        pre <= '0;
                        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    end else begin
                        pre <= pre + PRE_W'(1);
                    end

                    // Enable, segments and dp all derive from the same idx.
                    an_q  <= AN_LOW ? ~an_sel : an_sel;
                    seg_q <= blank[idx] ? SEG_BLANK : dec_seg;
                    dp_q  <= sh_dp[idx] & ~blank[idx];
                end

                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

    assign bus.segmentos_o = seg_q;
    assign bus.dp_o        = dp_q;
    assign bus.anodos_o    = an_q;

endmodule

// File: tb/tb_module_7seg_scan.sv
// -----------------------------------------------------------------------------
// tb_module_7seg_scan
// Directed bench for module_7seg_scan with N_DIGITS=4, REFRESH_DIV=4,
// ANODE_ACTIVE_LOW=1. Two instances share stimulus: dut_hex (HEX_MODE=1) and
// dut_dec (HEX_MODE=0). Expectations follow LEADING_ZERO_BLANK_EN when defined.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_module_7seg_scan;
    import module_7seg_pkg::*;

    localparam int N   = 4;
    localparam int DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    module_7seg_scan_if #(.N_DIGITS(N)) bus_h ();
    module_7seg_scan_if #(.N_DIGITS(N)) bus_d ();

    module_7seg_scan #(
        .N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_MODE(1), .ANODE_ACTIVE_LOW(1)
    ) dut_hex (
        .clk (clk),
        .rst (rst),
        .bus (bus_h)
    );

    module_7seg_scan #(
        .N_DIGITS(N), .REFRESH_DIV(DIV), .HEX_MODE(0), .ANODE_ACTIVE_LOW(1)
    ) dut_dec (
        .clk (clk),
        .rst (rst),
        .bus (bus_d)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] p, input logic ld);
        bus_h.data_i = d;
        bus_h.dp_i   = p;
        bus_h.load_i = ld;
        bus_d.data_i = d;
        bus_d.dp_i   = p;
        bus_d.load_i = ld;
    endtask

    // One-cycle load pulse; returns on the falling edge after the capture edge.
    task automatic load(input logic [15:0] d, input logic [3:0] p);
        drive(d, p, 1'b1);
        step(1);
        drive(d, p, 1'b0);
    endtask

    function automatic logic [3:0] an_of(input int d);
        an_of = ~(4'b0001 << d);
    endfunction

    // Pattern of a digit whose shadow code is 0.
    function automatic logic [6:0] zero_seg(input int d);
        zero_seg = (LZB && d != 0) ? 7'b000_0000 : 7'b111_1110;
    endfunction

    task automatic wait_digit(input int d, input string tag);
        int k;
        k = 0;
        while (bus_h.anodos_o !== an_of(d) && k < 64) begin
            step(1);
            k++;
        end
        check({tag, "_en"}, bus_h.anodos_o, an_of(d));
    endtask

    task automatic show(input string tag, input int d, input logic [6:0] seg_h,
                        input logic [6:0] seg_d, input logic dp);
        wait_digit(d, tag);
        check({tag, "_seg_hex"}, bus_h.segmentos_o, seg_h);
        check({tag, "_seg_dec"}, bus_d.segmentos_o, seg_d);
        check({tag, "_dp"},      bus_h.dp_o,        dp);
    endtask

    initial begin
        rst = 1'b1;
        drive(16'h0000, 4'b0000, 1'b0);
        step(3);

        // Reset state
        check("rst_an",     bus_h.anodos_o,    4'hF);
        check("rst_seg",    bus_h.segmentos_o, 7'b000_0000);
        check("rst_dp",     bus_h.dp_o,        1'b0);
        check("rst_an_dec", bus_d.anodos_o,    4'hF);

        // Release: one cycle of reset values, then 4-cycle slots per digit
        rst = 1'b0;
        step(1);
        check("rel_hold_an",  bus_h.anodos_o,    4'hF);
        check("rel_hold_seg", bus_h.segmentos_o, 7'b000_0000);
        for (int k = 0; k < 17; k++) begin
            step(1);
            check($sformatf("scan_an_%0d", k),  bus_h.anodos_o,    an_of((k / 4) % 4));
            check($sformatf("scan_seg_%0d", k), bus_h.segmentos_o, zero_seg((k / 4) % 4));
        end

        // Decimal digits with a decimal point on digit 2
        load(16'h1234, 4'b0100);
        step(1);
        show("dec_d0", 0, 7'b011_0011, 7'b011_0011, 1'b0);
        show("dec_d1", 1, 7'b111_1001, 7'b111_1001, 1'b0);
        show("dec_d2", 2, 7'b110_1101, 7'b110_1101, 1'b1);
        show("dec_d3", 3, 7'b011_0000, 7'b011_0000, 1'b0);

        // Letters: decoded with HEX_MODE=1, blank with HEX_MODE=0
        load(16'hABCF, 4'b0000);
        step(1);
        show("hex_d0", 0, 7'b100_0111, 7'b000_0000, 1'b0);
        show("hex_d1", 1, 7'b100_1110, 7'b000_0000, 1'b0);
        show("hex_d2", 2, 7'b001_1111, 7'b000_0000, 1'b0);
        show("hex_d3", 3, 7'b111_0111, 7'b000_0000, 1'b0);

        // Leading zeros, with dp requested on the two zero digits
        load(16'h0045, 4'b1100);
        step(1);
        show("lz_d3", 3, LZB ? 7'b000_0000 : 7'b111_1110, LZB ? 7'b000_0000 : 7'b111_1110, !LZB);
        show("lz_d2", 2, LZB ? 7'b000_0000 : 7'b111_1110, LZB ? 7'b000_0000 : 7'b111_1110, !LZB);
        show("lz_d1", 1, 7'b011_0011, 7'b011_0011, 1'b0);
        show("lz_d0", 0, 7'b101_1011, 7'b101_1011, 1'b0);

        load(16'h0000, 4'b0000);
        step(1);
        for (int d = 0; d < N; d++) begin
            show($sformatf("zero_d%0d", d), d, zero_seg(d), zero_seg(d), 1'b0);
        end

        // Load coincident with tick: one-cycle reset, then count edges from release
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(4);                        // after edge 4; edge 5 carries the tick
        drive(16'h9999, 4'b0000, 1'b1);
        step(1);
        drive(16'h9999, 4'b0000, 1'b0);
        check("tk_old_an",  bus_h.anodos_o,    4'b1110);
        check("tk_old_seg", bus_h.segmentos_o, 7'b111_1110);
        step(1);
        check("tk_new_an",      bus_h.anodos_o,    4'b1101);
        check("tk_new_seg",     bus_h.segmentos_o, 7'b111_0011);
        check("tk_new_seg_dec", bus_d.segmentos_o, 7'b111_0011);

        // Reset in the middle of digit 2's slot
        step(5);
        check("mid_d2_an",  bus_h.anodos_o,    4'b1011);
        check("mid_d2_seg", bus_h.segmentos_o, 7'b111_0011);
        rst = 1'b1;
        step(1);
        check("rr_an",  bus_h.anodos_o,    4'hF);
        check("rr_seg", bus_h.segmentos_o, 7'b000_0000);
        check("rr_dp",  bus_h.dp_o,        1'b0);
        rst = 1'b0;
        step(1);
        check("rr_hold_an", bus_h.anodos_o, 4'hF);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check($sformatf("rr_scan_an_%0d", k),  bus_h.anodos_o,    an_of(k < 4 ? 0 : 1));
            check($sformatf("rr_scan_seg_%0d", k), bus_h.segmentos_o, zero_seg(k < 4 ? 0 : 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/module_7seg_scan.md
# module_7seg_scan

Time-multiplexed driver for a parametrised bank of common-anode/common-cathode 7-segment digits. It latches a packed vector of 4-bit digit codes and scans the digits at a programmable refresh rate. On each scan step it drives one digit enable and that digit's decoded `abc_defg` pattern plus its decimal point. It sits between the datapath's result registers and the board display pins, replacing per-digit combinational decoders wired to dedicated pins.

## Interface
- `N_DIGITS`, 4: number of multiplexed digits, 1..8.
- `REFRESH_DIV`, 27000: clock cycles per digit slot, ≥2.
- `HEX_MODE`, 1: 1 decodes codes A–F as letters; 0 blanks codes ≥10.
- `ANODE_ACTIVE_LOW`, 1: digit-enable polarity; segments are always active-high `abc_defg`.
- `clk` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `data_i` in 4*N_DIGITS: packed digit codes; digit 0 is bits [3:0] (least significant, rightmost).
- `dp_i` in N_DIGITS: decimal-point request per digit.
- `load_i` in 1: capture `data_i`/`dp_i` into the shadow register.
- `segmentos_o` out 7: `abc_defg` pattern for the active digit.
- `dp_o` out 1: decimal point for the active digit.
- `anodos_o` out N_DIGITS: one-hot digit enable, polarity per `ANODE_ACTIVE_LOW`.

## Operation
- Shadow register: captures `data_i` and `dp_i` on a clock edge where `load_i`=1 and otherwise holds its value. Display content comes only from the shadow register, never directly from `data_i`.
- Prescaler `pre` counts 0..REFRESH_DIV-1. `tick` is asserted when `pre`=REFRESH_DIV-1, and `pre` then wraps to 0.
- Scan index `idx` (width $clog2(N_DIGITS), min 1) advances on `tick`. It wraps from N_DIGITS-1 to 0. With N_DIGITS=1, `idx` stays at 0.
- States: RESET (all outputs off) → SCAN (free-running, no other states). `rst` in any state returns to RESET on the same edge.
- Decode: codes 0–9 use the standard patterns (0=111_1110 … 9=111_0011).
  - HEX_MODE=1: A=111_0111, b=001_1111, C=100_1110, d=011_1101, E=100_1111, F=100_0111.
  - HEX_MODE=0: codes 10–15 give 000_0000.
- Output register: each cycle it loads `anodos_o` (enable for `idx`), `segmentos_o` (decode of shadow nibble `idx`) and `dp_o` (shadow `dp[idx]`). All three come from the same `idx`, so they always change on the same edge and can never disagree.
- Reset values:
  - `pre`=0, `idx`=0, shadow data=0, shadow dp=0.
  - `segmentos_o`=000_0000, `dp_o`=0.
  - `anodos_o` all inactive: all ones when ANODE_ACTIVE_LOW=1, else all zeros.

## Timing
- The first cycle after `rst` deasserts, the outputs still hold reset values. The second cycle shows digit 0 with shadow contents (0 → 111_1110).
- `load_i` latency: shadow updates at edge k. If the new digit is the one selected, it appears on the outputs at edge k+1.
- Digit slot length is exactly REFRESH_DIV cycles. Full frame = N_DIGITS*REFRESH_DIV cycles.
- `load_i` coincident with `tick`: both take effect. The output at the next edge shows the new digit index with the new data.
- `rst` mid-slot: all counters clear on that edge, and scanning restarts at digit 0 with a full slot.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined: starting from digit N_DIGITS-1 and moving downward, each digit is blanked while its code is 0 and it is not digit 0. Blanking stops at the first nonzero code.
  - A blanked digit outputs `segmentos_o`=000_0000 and `dp_o`=0. Its enable line is still driven in its slot, so scan timing is unchanged.
  - Blank flags are computed combinationally from the shadow register.
- Not defined: every digit is always decoded, including leading zeros.

## Structure
- Package `module_7seg_pkg` holds:
  - the `seg_t` typedef (logic [6:0]);
  - `SEG_BLANK`;
  - the localparam table of the 16 digit patterns.
- Sub-module `module_7seg_dec` (4-bit code + `HEX_MODE` → `seg_t`) is pure combinational logic and is instantiated once, on the selected nibble.
- The top level holds the prescaler, the scan index, the shadow register, the blanking logic and the output register.

## Test plan
- Reset release with N_DIGITS=4, REFRESH_DIV=4, ANODE_ACTIVE_LOW=1:
  - during `rst`, `anodos_o`=1111 and `segmentos_o`=0000000;
  - 2 cycles after release, `anodos_o`=1110 and `segmentos_o`=1111110;
  - enables then step 1101/1011/0111 every 4 cycles and wrap to 1110.
- Load 0x1234 with `dp_i`=0100: the digit 0 slot shows 0110011 (4), digit 1 shows 1111001 (3), digit 2 shows 1101101 (2) with `dp_o`=1, digit 3 shows 0110000 (1).
- HEX_MODE=1, load 0xAbCF: the slots show 1000111, 1001110, 0011111, 1110111 in digit 0..3 order. Repeat with HEX_MODE=0: all four slots show 0000000.
- `LEADING_ZERO_BLANK_EN` defined, load 0x0045: digits 3 and 2 show 0000000 while their enables still pulse. Load 0x0000: only digit 0 shows 1111110. Without the macro, 0x0045 shows 1111110 on digits 3 and 2.
- Assert `load_i` (0x9999) on the same cycle as `tick`: the next edge shows 1110011 on the new digit, with no stale old-data cycle.
- Assert `rst` for one cycle mid-slot of digit 2: outputs clear the next edge, digit 0 resumes a full 4-cycle slot, and the shadow reads 0.
